// File: rtl/store_buffer_if.sv
// Core-facing store/load request bus of the store buffer.
// The core drives the master side and the buffer implements the slave side.
interface store_buffer_if #(
    parameter int unsigned REG_WIDTH = 64
);
    logic                 st_valid;
    logic                 st_ready;
    logic [REG_WIDTH-1:0] st_addr;
    logic [REG_WIDTH-1:0] st_data;
    logic [1:0]           st_width;

    logic                 ld_req;
    logic [REG_WIDTH-1:0] ld_addr;
    logic [1:0]           ld_width;
    logic                 ld_unsigned;
    logic                 ld_stall;
    logic                 ld_rvalid;

    modport master (
        output st_valid, st_addr, st_data, st_width,
        output ld_req, ld_addr, ld_width, ld_unsigned,
        input  st_ready, ld_stall, ld_rvalid
    );

    modport slave (
        input  st_valid, st_addr, st_data, st_width,
        input  ld_req, ld_addr, ld_width, ld_unsigned,
        output st_ready, ld_stall, ld_rvalid
    );
endinterface

// File: rtl/store_buffer.sv
// Store FIFO in front of the single-ported data_mem: loads win the port, queued
// stores drain in order on free cycles, and loads wait on granule-overlapping stores.
module store_buffer #(
    parameter int unsigned REG_WIDTH  = 64,
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    store_buffer_if.slave        core,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic [1:0]           mem_width,
    output logic                 mem_sign,
    output logic [REG_WIDTH-1:0] mem_addr,
    output logic [REG_WIDTH-1:0] mem_wdata,
    output logic                 empty
);
    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
    localparam int unsigned GRAN_W = ADDR_WIDTH - 3;

    typedef struct packed {
        logic [REG_WIDTH-1:0] addr;
        logic [REG_WIDTH-1:0] data;
        logic [1:0]           width;
        logic [GRAN_W-1:0]    g_start;
        logic [GRAN_W-1:0]    g_end;
    } entry_t;

    entry_t            entries [DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [CNT_W-1:0]  count;

    logic              full;
    logic              push;
    logic              issue;
    logic              drain;
    logic [DEPTH-1:0]  hit;
    logic [GRAN_W-1:0] ld_g_start;
    logic [GRAN_W-1:0] ld_g_end;
    logic [GRAN_W-1:0] st_g_start;
    logic [GRAN_W-1:0] st_g_end;

    // Granule holding the last byte of an access, wrapping within the low address window.
    function automatic logic [GRAN_W-1:0] end_gran(input logic [ADDR_WIDTH-1:0] addr,
                                                   input logic [1:0]            width);
        logic [ADDR_WIDTH-1:0] last;
        last = addr + ((ADDR_WIDTH'(1) << width) - ADDR_WIDTH'(1));
        return last[ADDR_WIDTH-1:3];
    endfunction

    // Slot idx is occupied when it lies within count entries of head.
    function automatic logic slot_live(input logic [PTR_W-1:0] idx,
                                       input logic [PTR_W-1:0] hd,
                                       input logic [CNT_W-1:0] cnt);
        logic [PTR_W-1:0] off;
        off = idx - hd;
        return CNT_W'(off) < cnt;
    endfunction

    assign ld_g_start = core.ld_addr[ADDR_WIDTH-1:3];
    assign ld_g_end   = end_gran(core.ld_addr[ADDR_WIDTH-1:0], core.ld_width);
    assign st_g_start = core.st_addr[ADDR_WIDTH-1:3];
    assign st_g_end   = end_gran(core.st_addr[ADDR_WIDTH-1:0], core.st_width);

    // Conservative overlap of the load against every occupied slot.
    always_comb begin
        hit = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (slot_live(PTR_W'(i), head, count) &&
                ((ld_g_start == entries[i].g_start) || (ld_g_start == entries[i].g_end) ||
                 (ld_g_end   == entries[i].g_start) || (ld_g_end   == entries[i].g_end))) begin
                hit[i] = 1'b1;
            end
        end
    end

    assign full          = (count == CNT_W'(DEPTH));
    assign empty         = (count == '0);
    assign core.st_ready = !rst && !full;
    assign push          = core.st_valid && core.st_ready;
    assign core.ld_stall = core.ld_req && (rst || (|hit) || full);
    assign issue         = core.ld_req && !core.ld_stall;
    assign drain         = !rst && !issue && !empty;

    // Port arbitration: load issue, then head drain, else idle.
    always_comb begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_width = 2'd0;
        mem_sign  = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (issue) begin
            mem_read  = 1'b1;
            mem_width = core.ld_width;
            mem_sign  = core.ld_unsigned;
            mem_addr  = core.ld_addr;
        end else if (drain) begin
            mem_write = 1'b1;
            mem_width = entries[head].width;
            mem_addr  = entries[head].addr;
            mem_wdata = entries[head].data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head           <= '0;
            tail           <= '0;
            count          <= '0;
            core.ld_rvalid <= 1'b0;
        end else begin
            if (push) begin
                tail <= tail + PTR_W'(1);
            end
            if (drain) begin
                head <= head + PTR_W'(1);
            end
            case ({push, drain})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            core.ld_rvalid <= issue;
        end
    end

    // Payload storage; granules are precomputed so the overlap check sees only registers.
    always_ff @(posedge clk) begin
        if (push) begin
            entries[tail] <= '{addr:    core.st_addr,
                               data:    core.st_data,
                               width:   core.st_width,
                               g_start: st_g_start,
                               g_end:   st_g_end};
        end
    end
endmodule

// File: tb/tb_store_buffer.sv
// Randomized bench for store_buffer: a queue-based reference model predicts every
// port each cycle, and a byte-array data_mem model closes the store-to-load loop.
module tb_store_buffer;
    localparam int unsigned RW        = 64;
    localparam int unsigned AW        = 10;
    localparam int unsigned DEPTH     = 4;
    localparam int unsigned MEM_BYTES = 1024;

    typedef struct {
        logic [63:0] addr;
        logic [63:0] data;
        logic [1:0]  width;
    } st_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read, mem_write, mem_sign, empty;
    logic [1:0]  mem_width;
    logic [63:0] mem_addr, mem_wdata;

    store_buffer_if #(.REG_WIDTH(RW)) sb_if ();

    store_buffer #(.REG_WIDTH(RW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .core      (sb_if),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_width (mem_width),
        .mem_sign  (mem_sign),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .empty     (empty)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]  dmem [MEM_BYTES];
    logic [7:0]  rmem [MEM_BYTES];
    logic [63:0] rdata;
    logic [63:0] raw_d;
    st_t         q [$];
    logic        exp_rv    = 1'b0;
    logic [63:0] exp_rdata = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] extend(input logic [63:0] raw, input logic [1:0] w,
                                           input logic uns);
        int          bits;
        logic [63:0] mask;
        bits = 8 << w;
        if (bits == 64) return raw;
        mask = (64'(1) << bits) - 64'(1);
        if (!uns && raw[bits-1]) return raw | ~mask;
        return raw & mask;
    endfunction

    // data_mem stand-in: write at the edge, registered read data.
    always @(posedge clk) begin
        if (mem_write) begin
            for (int b = 0; b < (1 << mem_width); b++)
                dmem[(int'(mem_addr[9:0]) + b) % MEM_BYTES] <= mem_wdata[8*b +: 8];
        end
        if (mem_read) begin
            raw_d = '0;
            for (int b = 0; b < (1 << mem_width); b++)
                raw_d[8*b +: 8] = dmem[(int'(mem_addr[9:0]) + b) % MEM_BYTES];
            rdata <= extend(raw_d, mem_width, mem_sign);
        end
    end

    function automatic int gran_start(input logic [63:0] a);
        return int'(a % 64'(MEM_BYTES)) / 8;
    endfunction

    function automatic int gran_end(input logic [63:0] a, input logic [1:0] w);
        return int'((a % 64'(MEM_BYTES) + (64'(1) << w) - 64'(1)) % 64'(MEM_BYTES)) / 8;
    endfunction

    function automatic logic overlaps(input logic [63:0] la, input logic [1:0] lw,
                                      input logic [63:0] sa, input logic [1:0] sw);
        int ls, le, ss, se;
        ls = gran_start(la); le = gran_end(la, lw);
        ss = gran_start(sa); se = gran_end(sa, sw);
        return (ls == ss) || (ls == se) || (le == ss) || (le == se);
    endfunction

    // Program-order load value: committed memory overlaid with pending stores, oldest first.
    function automatic logic [63:0] ref_load(input logic [63:0] a, input logic [1:0] w,
                                             input logic uns);
        logic [63:0] raw;
        int          idx;
        raw = '0;
        for (int b = 0; b < (1 << w); b++) begin
            idx = int'((a + 64'(b)) % 64'(MEM_BYTES));
            raw[8*b +: 8] = rmem[idx];
            foreach (q[k])
                for (int eb = 0; eb < (1 << q[k].width); eb++)
                    if (int'((q[k].addr + 64'(eb)) % 64'(MEM_BYTES)) == idx)
                        raw[8*b +: 8] = q[k].data[8*eb +: 8];
        end
        return extend(raw, w, uns);
    endfunction

    // One clock: drive at negedge, check everything, then advance the model at posedge.
    task automatic step(input logic r, input logic sv, input logic [63:0] sa,
                        input logic [63:0] sd, input logic [1:0] sw,
                        input logic lr, input logic [63:0] la, input logic [1:0] lw,
                        input logic lu, output logic stalled);
        logic        e_full, e_ovl, e_ready, e_stall, e_issue, e_drain;
        logic [63:0] e_addr, e_wdata, nxt_rdata;
        logic [1:0]  e_width;
        st_t         h;
        rst = r;
        sb_if.st_valid = sv; sb_if.st_addr = sa; sb_if.st_data = sd; sb_if.st_width = sw;
        sb_if.ld_req = lr; sb_if.ld_addr = la; sb_if.ld_width = lw; sb_if.ld_unsigned = lu;
        #1;
        e_full = (q.size() == DEPTH);
        e_ovl  = 1'b0;
        foreach (q[k]) if (overlaps(la, lw, q[k].addr, q[k].width)) e_ovl = 1'b1;
        e_ready = !r && !e_full;
        e_stall = lr && (r || e_ovl || e_full);
        e_issue = lr && !e_stall;
        e_drain = !r && !e_issue && (q.size() != 0);
        e_addr = '0; e_wdata = '0; e_width = 2'd0;
        if (e_issue) begin
            e_addr = la; e_width = lw;
        end else if (e_drain) begin
            h = q[0];
            e_addr = h.addr; e_width = h.width; e_wdata = h.data;
        end
        check("st_ready",  64'(sb_if.st_ready), 64'(e_ready));
        check("ld_stall",  64'(sb_if.ld_stall), 64'(e_stall));
        check("mem_read",  64'(mem_read),       64'(e_issue));
        check("mem_write", 64'(mem_write),      64'(e_drain));
        check("mem_addr",  mem_addr,            e_addr);
        check("mem_width", 64'(mem_width),      64'(e_width));
        check("mem_sign",  64'(mem_sign),       64'(e_issue && lu));
        check("mem_wdata", mem_wdata,           e_wdata);
        check("empty",     64'(empty),          64'(q.size() == 0));
        check("ld_rvalid", 64'(sb_if.ld_rvalid), 64'(exp_rv));
        if (exp_rv) check("ld_rdata", rdata, exp_rdata);
        nxt_rdata = e_issue ? ref_load(la, lw, lu) : '0;
        stalled = e_stall;
        @(posedge clk);
        if (r) begin
            q.delete();
        end else begin
            if (e_drain) begin
                h = q.pop_front();
                for (int eb = 0; eb < (1 << h.width); eb++)
                    rmem[int'((h.addr + 64'(eb)) % 64'(MEM_BYTES))] = h.data[8*eb +: 8];
            end
            if (sv && e_ready) q.push_back('{addr: sa, data: sd, width: sw});
        end
        exp_rv    = e_issue;
        exp_rdata = nxt_rdata;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        logic s;
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, 2'd0, 1'b0, '0, 2'd0, 1'b0, s);
    endtask

    function automatic logic [63:0] rand_addr();
        logic [63:0] a;
        if ($urandom_range(0, 9) == 0) a = 64'h3F8 + 64'($urandom_range(0, 7));
        else                           a = 64'($urandom_range(0, 95));
        if ($urandom_range(0, 3) == 0) a = a | (64'($urandom_range(1, 3)) << 32);
        return a;
    endfunction

    initial begin
        logic        s;
        logic        lr, lu, hold;
        logic [63:0] la;
        logic [1:0]  lw;
        for (int i = 0; i < MEM_BYTES; i++) begin
            dmem[i] = 8'($urandom);
            rmem[i] = dmem[i];
        end
        rst = 1'b1;
        sb_if.st_valid = 1'b0; sb_if.st_addr = '0; sb_if.st_data = '0; sb_if.st_width = 2'd0;
        sb_if.ld_req = 1'b0; sb_if.ld_addr = '0; sb_if.ld_width = 2'd0; sb_if.ld_unsigned = 1'b0;
        @(negedge clk);

        // Reset, then release with no traffic.
        step(1'b1, 1'b0, '0, '0, 2'd0, 1'b0, '0, 2'd0, 1'b0, s);
        step(1'b1, 1'b1, 64'h40, 64'h1, 2'd3, 1'b1, 64'h40, 2'd3, 1'b0, s);
        idle(2);

        // Single sd drain, then read it back.
        step(1'b0, 1'b1, 64'h10, 64'h1122334455667788, 2'd3, 1'b0, '0, 2'd0, 1'b0, s);
        idle(2);
        step(1'b0, 1'b0, '0, '0, 2'd0, 1'b1, 64'h10, 2'd3, 1'b0, s);
        idle(1);
        check("sd_readback", rdata, 64'h1122334455667788);

        // Overlap stall: sw 0x100 against a held lb 0x102; lb 0x108 is independent.
        step(1'b0, 1'b1, 64'h100, 64'hA1B2C3D4, 2'd2, 1'b1, 64'h102, 2'd0, 1'b0, s);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0, '0, 2'd0, 1'b1, 64'h102, 2'd0, 1'b0, s);
        step(1'b0, 1'b1, 64'h100, 64'h55667788, 2'd2, 1'b0, '0, 2'd0, 1'b0, s);
        step(1'b0, 1'b0, '0, '0, 2'd0, 1'b1, 64'h108, 2'd0, 1'b1, s);
        idle(3);

        // Fill with a non-overlapping load held, forcing a drain.
        for (int i = 0; i < 4; i++)
            step(1'b0, 1'b1, 64'h200 + 64'(8 * i), 64'(i + 1) * 64'h0101010101010101, 2'd3,
                 1'b1, 64'h280, 2'd3, 1'b0, s);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0, '0, 2'd0, 1'b1, 64'h280, 2'd3, 1'b0, s);
        idle(5);

        // Pointer wrap, then a store whose end granule wraps to granule 0.
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b1, 64'h300 + 64'(8 * i), {$urandom, $urandom}, 2'd3,
                 1'b0, '0, 2'd0, 1'b0, s);
            if (i % 2 == 1) idle(1);
        end
        step(1'b0, 1'b1, 64'h3FC, 64'hDEADBEEFCAFEF00D, 2'd3, 1'b0, '0, 2'd0, 1'b0, s);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, '0, '0, 2'd0, 1'b1, 64'h0, 2'd0, 1'b1, s);
        idle(2);

        // Reset with three stores pending; their targets keep old contents.
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'b1, 64'h380 + 64'(8 * i), 64'hFFFF_0000_FFFF_0000, 2'd3,
                 1'b1, 64'h2C0, 2'd3, 1'b0, s);
        step(1'b1, 1'b0, '0, '0, 2'd0, 1'b0, '0, 2'd0, 1'b0, s);
        idle(3);
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'b0, '0, '0, 2'd0, 1'b1, 64'h380 + 64'(8 * i), 2'd3, 1'b0, s);
        idle(1);

        // Random traffic; a stalled load is held stable.
        lr = 1'b0; la = '0; lw = 2'd0; lu = 1'b0; hold = 1'b0;
        for (int c = 0; c < 2500; c++) begin
            if (!hold) begin
                lr = ($urandom_range(0, 1) == 1);
                la = rand_addr();
                lw = 2'($urandom_range(0, 3));
                lu = 1'($urandom);
            end
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 1) == 1), rand_addr(),
                 {$urandom, $urandom}, 2'($urandom_range(0, 3)), lr, la, lw, lu, s);
            hold = lr && s;
        end
        idle(8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
